// File: rtl/fetch_ctrl_pkg.sv
// Shared constants for the fetch redirect controller: opcode values and state encoding.
package fetch_ctrl_pkg;

    localparam logic [4:0] OP_CALL = 5'b00101;
    localparam logic [4:0] OP_RET  = 5'b00010;
    localparam logic [4:0] OP_RTI  = 5'b00011;
    localparam logic [4:0] OP_JZ   = 5'b11000;
    localparam logic [4:0] OP_JN   = 5'b11001;
    localparam logic [4:0] OP_JC   = 5'b11010;
    localparam logic [4:0] OP_JMP  = 5'b11011;
    localparam logic [4:0] OP_LDM  = 5'b10010;

    localparam logic [1:0] ST_RUN          = 2'd0;
    localparam logic [1:0] ST_LDM_IMM      = 2'd1;
    localparam logic [1:0] ST_WAIT_RESOLVE = 2'd2;

endpackage

// File: rtl/fetch_redirect_controller_opcode_classifier.sv
// Decodes a fetched opcode into "LDM prefix" and "control transfer" classes.
module opcode_classifier
    import fetch_ctrl_pkg::*;
(
    input  logic [4:0] i_opcode,
    output logic       o_is_ldm,
    output logic       o_is_transfer
);

    always_comb begin
        o_is_ldm      = (i_opcode == OP_LDM);
        o_is_transfer = 1'b0;
        case (i_opcode)
            OP_CALL, OP_RET, OP_RTI, OP_JZ, OP_JN, OP_JC, OP_JMP: o_is_transfer = 1'b1;
            default: o_is_transfer = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_redirect_controller.sv
// Control end of the fetch interface: stalls behind control transfers, tracks LDM
// immediates, injects pending external interrupts and counts stall cycles.
module fetch_redirect_controller
    import fetch_ctrl_pkg::*;
#(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [INSTR_WIDTH-1:0] i_instr,
    input  logic [PC_WIDTH-1:0]    i_pc_inc,
    input  logic                   i_interrupt,
    input  logic                   i_hazard_instruction,
    input  logic                   i_ext_interrupt,
    input  logic                   i_resolve_valid,
    input  logic                   i_resolve_taken,
    input  logic [PC_WIDTH-1:0]    i_resolve_target,
    input  logic                   i_mem_stall,
    output logic                   o_fetch_enable,
    output logic                   o_interrupt_signal,
    output logic [PC_WIDTH-1:0]    o_pc_new,
    output logic                   o_branch_decision,
    output logic                   o_ifid_enable,
    output logic                   o_ifid_flush,
    output logic                   o_ldm_imm,
    output logic [PC_WIDTH-1:0]    o_pc_fwd,
    output logic [CNT_WIDTH-1:0]   o_stall_cycles
);

    localparam logic [CNT_WIDTH-1:0] L_CNT_ONE = CNT_WIDTH'(1);

    logic [1:0]           r_state;
    logic                 r_int_pending;
    logic [CNT_WIDTH-1:0] r_stall_cnt;

    logic [1:0] w_state_next;
    logic       w_pending_next;
    logic       w_is_ldm;
    logic       w_is_transfer;
    logic       w_hazard_ldm;
    logic       w_hazard_wait;
    logic       w_fetch_enable;
    logic       w_ifid_enable;
    logic       w_ifid_flush;
    logic       w_interrupt;
    logic       w_branch;
    logic       w_ldm_imm;
    logic       w_unused_bits;

    // Only the opcode field and flags matter here; the echo and operand bits are passed by.
    assign w_unused_bits = ^{i_instr[INSTR_WIDTH-6:0], i_interrupt};

    opcode_classifier u_classifier (
        .i_opcode      (i_instr[INSTR_WIDTH-1 -: 5]),
        .o_is_ldm      (w_is_ldm),
        .o_is_transfer (w_is_transfer)
    );

    assign w_hazard_ldm  = i_hazard_instruction & w_is_ldm;
    assign w_hazard_wait = i_hazard_instruction & (w_is_transfer | ~w_is_ldm);

    always_comb begin
        w_state_next   = r_state;
        w_pending_next = r_int_pending | i_ext_interrupt;
        w_fetch_enable = 1'b0;
        w_ifid_enable  = 1'b0;
        w_ifid_flush   = 1'b0;
        w_interrupt    = 1'b0;
        w_branch       = 1'b0;
        w_ldm_imm      = 1'b0;
        if (i_reset) begin
            w_ifid_flush = 1'b1;
        end else if (!i_mem_stall) begin
            case (r_state)
                ST_RUN: begin
                    w_fetch_enable = 1'b1;
                    w_ifid_enable  = 1'b1;
                    if (w_hazard_ldm) begin
                        w_state_next = ST_LDM_IMM;
                    end else if (w_hazard_wait) begin
                        w_state_next = ST_WAIT_RESOLVE;
                    end else if (r_int_pending) begin
                        w_interrupt    = 1'b1;
                        w_pending_next = 1'b0;
                        w_state_next   = ST_WAIT_RESOLVE;
                    end
                end
                ST_LDM_IMM: begin
                    w_fetch_enable = 1'b1;
                    w_ifid_enable  = 1'b1;
                    w_ldm_imm      = 1'b1;
                    w_state_next   = ST_RUN;
                end
                ST_WAIT_RESOLVE: begin
                    w_ifid_enable = 1'b1;
                    w_ifid_flush  = 1'b1;
                    if (i_resolve_valid) begin
                        w_fetch_enable = 1'b1;
                        w_state_next   = ST_RUN;
                        // A not-taken resolve lets the held word proceed instead of flushing it.
                        if (i_resolve_taken) begin
                            w_branch = 1'b1;
                        end else begin
                            w_ifid_flush = 1'b0;
                        end
                    end
                end
                default: w_state_next = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= ST_RUN;
            r_int_pending <= 1'b0;
            r_stall_cnt   <= '0;
        end else begin
            if (!w_fetch_enable && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + L_CNT_ONE;
            end
            if (!i_mem_stall) begin
                r_state       <= w_state_next;
                r_int_pending <= w_pending_next;
            end
        end
    end

    assign o_fetch_enable     = w_fetch_enable;
    assign o_ifid_enable      = w_ifid_enable;
    assign o_ifid_flush       = w_ifid_flush;
    assign o_interrupt_signal = w_interrupt;
    assign o_branch_decision  = w_branch;
    assign o_ldm_imm          = w_ldm_imm;
    assign o_pc_new           = w_branch ? i_resolve_target : '0;
    assign o_pc_fwd           = i_reset ? '0 : i_pc_inc;
    assign o_stall_cycles     = r_stall_cnt;

endmodule
